apb_slave_mem: RTL

- APB completer (responder) for the 8-bit APB fabric; it answers transfers issued by the APB master.
- The master decodes padd[8] into SEL1/SEL2. One instance of this block sits behind each select line and receives padd[7:0].
- It holds a local byte-wide register file, inserts a programmable number of wait states, and flags PSLVERR on out-of-range addresses and protocol violations.

---
 rtl/apb_pkg.sv | 32 +++
 rtl/apb_slave_regfile.sv | 38 +++
 rtl/apb_slave_mem.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and defaults for the APB completer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WAIT   = 2'b01,
        ACCESS = 2'b10
    } apb_state_e;

    // Why the current transfer will complete with PSLVERR set.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'b00,
        ERR_RANGE = 2'b01,
        ERR_PROTO = 2'b10
    } apb_err_e;

    function automatic logic is_err(input apb_err_e cause);
        return cause != ERR_NONE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_slave_regfile.sv
// ============================================================================
// Module      : apb_slave_regfile
// Description : DEPTH x DATA_W storage, synchronous write, combinational read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_regfile #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/apb_slave_mem.sv
// ============================================================================
// Module      : apb_slave_mem
// Description : APB completer with local register file, wait states, PSLVERR.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRST,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit         HAS_WAIT    = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_INIT   = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    apb_state_e        state_q,  state_d;
    apb_err_e          cause_q,  cause_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              write_q,  write_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;
    logic [3:0]        cnt_q,    cnt_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic              mem_we;
    logic              addr_range_err;
    logic              inputs_match;
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata;

    assign addr_range_err = (32'(PADDR) >= 32'(DEPTH));
    assign inputs_match   = (PADDR == addr_q) && (PWRITE == write_q) && (PWDATA == wdata_q);

    // ACCESS is only entered from IDLE (fresh PADDR) or from WAIT (where PADDR
    // already equals addr_q), so the read port can look ahead without a loop.
    assign raddr = (state_q == IDLE) ? PADDR : addr_q;

    apb_slave_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk_i   (PCLK),
        .rst_i   (PRST),
        .we_i    (mem_we),
        .waddr_i (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .raddr_i (raddr[IDX_W-1:0]),
        .rdata_o (rdata)
    );

    always_ff @(posedge PCLK or posedge PRST) begin
        if (PRST) begin
            state_q  <= IDLE;
            cause_q  <= ERR_NONE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        addr_d   = addr_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        prdata_d = prdata_q;
        mem_we   = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    if (PENABLE) begin
                        cause_d = ERR_PROTO;
                        state_d = ACCESS;
                    end else begin
                        cause_d = addr_range_err ? ERR_RANGE : ERR_NONE;
                        if (HAS_WAIT && !addr_range_err) begin
                            cnt_d   = WAIT_INIT;
                            state_d = WAIT;
                        end else begin
                            state_d = ACCESS;
                        end
                    end
                end
            end

            WAIT: begin
                if (!PSEL || !inputs_match) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    if (cnt_q == 4'd0) begin
                        state_d = ACCESS;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end

            ACCESS: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (PENABLE) begin
                    mem_we  = write_q && !is_err(cause_q);
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ACCESS && state_q != ACCESS) begin
            prdata_d = (!write_d && !is_err(cause_d)) ? rdata : '0;
        end
    end

    assign PREADY  = (state_q == ACCESS);
    assign PSLVERR = (state_q == ACCESS) && is_err(cause_q);
    assign PRDATA  = prdata_q;

endmodule

`default_nettype wire
